data_island_assembler: RTL and testbench

DATA_ISLAND_ASSEMBLER -- requirements
Module: data_island_assembler

---
 rtl/data_island_assembler_pkg.sv | 17 +
 rtl/data_island_assembler_if.sv | 30 +++
 rtl/data_island_assembler_bch_ecc_step.sv | 14 +
 rtl/data_island_assembler.sv | 90 +++++++++
 tb/tb_data_island_assembler.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/data_island_assembler_pkg.sv
// Shared HDMI data-island constants and types.
// BCH parity polynomial and packet geometry live here.
package data_island_assembler_pkg;
  localparam logic [7:0] BCH_POLY = 8'h83;
  localparam int PACKET_PIXELS = 32;
  localparam int HEADER_BITS = 24;
  localparam int SUB_BITS = 56;
  localparam int NUM_SUBS = 4;

  typedef logic [4:0] cnt_t;
  typedef logic [7:0] ecc_t;
  typedef logic [NUM_SUBS-1:0][SUB_BITS-1:0] sub_arr_t;

  localparam cnt_t HDR_END = cnt_t'(HEADER_BITS);
  localparam cnt_t SUB_END = cnt_t'(SUB_BITS / 2);
  localparam cnt_t LAST_PIXEL = cnt_t'(PACKET_PIXELS - 1);
endpackage

// File: rtl/data_island_assembler_if.sv
// Packet source <-> assembler bundle.
// master = upstream packet source, slave = assembler.
interface data_island_assembler_if;
  import data_island_assembler_pkg::*;

  logic                   data_island_period;
  logic [HEADER_BITS-1:0] header;
  sub_arr_t               sub;
  cnt_t                   packet_pixel_counter;
  logic                   packet_enable;
  logic [8:0]             packet_data;

  modport master (
    output data_island_period,
    output header,
    output sub,
    input  packet_pixel_counter,
    input  packet_enable,
    input  packet_data
  );

  modport slave (
    input  data_island_period,
    input  header,
    input  sub,
    output packet_pixel_counter,
    output packet_enable,
    output packet_data
  );
endinterface

// File: rtl/data_island_assembler_bch_ecc_step.sv
// One serial BCH parity step: shift right, fold in poly on feedback.
// Purely combinational so steps can be chained within a cycle.
module bch_ecc_step
  import data_island_assembler_pkg::*;
(
  input  ecc_t ecc_i,
  input  logic bit_i,
  output ecc_t ecc_o
);
  logic fb;

  assign fb = ecc_i[0] ^ bit_i;
  assign ecc_o = (ecc_i >> 1) ^ (fb ? BCH_POLY : 8'h00);
endmodule

// File: rtl/data_island_assembler.sv
// Serialises one header + four subpackets per 32-pixel packet,
// appending running BCH parity after the payload bits.
module data_island_assembler
  import data_island_assembler_pkg::*;
(
  input logic                   clk_pixel,
  input logic                   reset,
  data_island_assembler_if.slave bus
);
  cnt_t                cnt_q, cnt_d;
  ecc_t                hecc_q, hecc_d, hecc_nxt;
  logic [3:0][7:0]     secc_q, secc_d;
  logic [3:0][7:0]     secc_mid, secc_nxt;
  logic [8:0]          pd_q, pd_d;
  logic                hbit;
  logic [3:0]          ev, od;
  logic                dip, last;

  assign dip = bus.data_island_period;
  assign last = (cnt_q == LAST_PIXEL);

  // Payload first, then the parity accumulated over it.
  always_comb begin
    hbit = 1'b0;
    ev = '0;
    od = '0;
    if (cnt_q < HDR_END) hbit = bus.header[cnt_q];
    else hbit = hecc_q[cnt_q[2:0]];
    for (int i = 0; i < NUM_SUBS; i++) begin
      if (cnt_q < SUB_END) begin
        ev[i] = bus.sub[i][{cnt_q, 1'b0}];
        od[i] = bus.sub[i][{cnt_q, 1'b1}];
      end else begin
        ev[i] = secc_q[i][{cnt_q[1:0], 1'b0}];
        od[i] = secc_q[i][{cnt_q[1:0], 1'b1}];
      end
    end
  end

  bch_ecc_step u_hdr (
    .ecc_i(hecc_q),
    .bit_i(hbit),
    .ecc_o(hecc_nxt)
  );

  for (genvar g = 0; g < NUM_SUBS; g++) begin : g_sub
    bch_ecc_step u_even (
      .ecc_i(secc_q[g]),
      .bit_i(ev[g]),
      .ecc_o(secc_mid[g])
    );
    bch_ecc_step u_odd (
      .ecc_i(secc_mid[g]),
      .bit_i(od[g]),
      .ecc_o(secc_nxt[g])
    );
  end

  always_comb begin
    cnt_d = dip ? cnt_q + 5'd1 : '0;
    hecc_d = hecc_q;
    secc_d = secc_q;
    if (!dip || last) begin
      hecc_d = '0;
      secc_d = '0;
    end else begin
      if (cnt_q < HDR_END) hecc_d = hecc_nxt;
      if (cnt_q < SUB_END) secc_d = secc_nxt;
    end
    pd_d = dip ? {od, ev, hbit} : '0;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      cnt_q <= '0;
      hecc_q <= '0;
      secc_q <= '0;
      pd_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      hecc_q <= hecc_d;
      secc_q <= secc_d;
      pd_q <= pd_d;
    end
  end

  assign bus.packet_pixel_counter = cnt_q;
  assign bus.packet_enable = dip & last & ~reset;
  assign bus.packet_data = pd_q;
endmodule

// File: tb/tb_data_island_assembler.sv
// Directed bench for data_island_assembler with a packet-level
// reference model checked every cycle.
module tb_data_island_assembler;
  import data_island_assembler_pkg::*;

  logic clk_pixel = 1'b0;
  logic reset = 1'b1;
  data_island_assembler_if bus ();

  data_island_assembler dut (
    .clk_pixel(clk_pixel),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [4:0] exp_cnt = '0;
  logic [8:0] exp_pd = '0;
  logic [8:0] cap [32];
  int en_hits;
  int en_pos;

  function automatic logic [7:0] bch(input logic [63:0] bits, input int n);
    logic [7:0] e = 8'h00;
    logic fb;
    for (int i = 0; i < n; i++) begin
      fb = e[0] ^ bits[i];
      e = (e >> 1) ^ (fb ? 8'h83 : 8'h00);
    end
    return e;
  endfunction

  // Whole packet as bit streams: payload followed by its parity.
  function automatic logic [8:0] word(input logic [23:0] h,
                                      input sub_arr_t s, input int k);
    logic [31:0] hs;
    logic [63:0] ss;
    logic [8:0] w;
    hs = {bch({40'd0, h}, 24), h};
    w[0] = hs[k];
    for (int i = 0; i < 4; i++) begin
      ss = {bch({8'd0, s[i]}, 56), s[i]};
      w[1+i] = ss[2*k];
      w[5+i] = ss[2*k+1];
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_pixel) begin
    if (reset) begin
      exp_cnt <= '0;
      exp_pd <= '0;
    end else if (bus.data_island_period) begin
      exp_pd <= word(bus.header, bus.sub, int'(exp_cnt));
      exp_cnt <= exp_cnt + 5'd1;
    end else begin
      exp_cnt <= '0;
      exp_pd <= '0;
    end
  end

  always @(negedge clk_pixel) begin
    if (chk_en) begin
      check("cnt", 32'(bus.packet_pixel_counter), 32'(exp_cnt));
      check("pdata", 32'(bus.packet_data), 32'(exp_pd));
      check("enable", 32'(bus.packet_enable),
            32'(!reset && bus.data_island_period && exp_cnt == 5'd31));
    end
  end

  task automatic tick();
    @(posedge clk_pixel);
    #2;
  endtask

  task automatic send(input logic [23:0] h, input sub_arr_t s);
    bus.header = h;
    bus.sub = s;
    bus.data_island_period = 1'b1;
    en_hits = 0;
    en_pos = -1;
    for (int j = 0; j < 32; j++) begin
      if (bus.packet_enable) begin
        en_hits++;
        en_pos = j;
      end
      tick();
      cap[j] = bus.packet_data;
    end
  endtask

  initial begin
    sub_arr_t s;
    logic [7:0] hv;
    logic nz;
    bus.data_island_period = 1'b0;
    bus.header = '0;
    bus.sub = '0;
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_cnt", 32'(bus.packet_pixel_counter), 0);
    check("rst_pdata", 32'(bus.packet_data), 0);
    check("rst_enable", 32'(bus.packet_enable), 0);
    reset = 1'b0;
    repeat (2) tick();
    check("model_hecc", 32'(bch(64'h1, 24)), 32'h4A);

    send(24'h0, '0);
    nz = 1'b0;
    for (int j = 0; j < 32; j++) nz |= |cap[j];
    check("zero_pkt", 32'(nz), 0);

    send(24'h000001, '0);
    for (int k = 0; k < 8; k++) hv[k] = cap[24+k][0];
    check("hdr_ecc", 32'(hv), 32'h4A);
    check("hdr_bit0", 32'(cap[0][0]), 1);
    nz = 1'b0;
    for (int j = 1; j < 24; j++) nz |= cap[j][0];
    check("hdr_zeros", 32'(nz), 0);

    s = '0;
    s[2] = 56'h1;
    send(24'h0, s);
    check("sub2_even0", 32'(cap[0][3]), 1);
    nz = 1'b0;
    for (int j = 1; j < 28; j++) nz |= cap[j][3] | cap[j][7];
    check("sub2_even_rest", 32'(nz), 0);

    s[2] = 56'h2;
    send(24'h0, s);
    check("sub2_odd0", 32'(cap[0][7]), 1);
    check("sub2_odd_even0", 32'(cap[0][3]), 0);

    s[0] = 56'h0123456789ABCD;
    s[1] = 56'hFEDCBA98765432;
    s[2] = 56'h00FF00FF00FF00;
    s[3] = 56'h80000000000001;
    send(24'hABCDEF, s);
    check("en_hits", 32'(en_hits), 1);
    check("en_pos", 32'(en_pos), 31);
    s[1] = 56'h5555AAAA5555AA;
    send(24'h123456, s);
    check("en_hits2", 32'(en_hits), 1);
    check("en_pos2", 32'(en_pos), 31);

    bus.header = 24'h5A5A5A;
    bus.data_island_period = 1'b1;
    repeat (13) tick();
    bus.data_island_period = 1'b0;
    tick();
    check("abort_cnt", 32'(bus.packet_pixel_counter), 0);
    check("abort_pdata", 32'(bus.packet_data), 0);
    send(24'h5A5A5A, s);

    bus.data_island_period = 1'b1;
    repeat (20) tick();
    reset = 1'b1;
    tick();
    check("rst20_cnt", 32'(bus.packet_pixel_counter), 0);
    check("rst20_pdata", 32'(bus.packet_data), 0);
    check("rst20_enable", 32'(bus.packet_enable), 0);
    tick();
    reset = 1'b0;
    send(24'hC3C3C3, s);
    bus.data_island_period = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
